pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges cache-miss stalls, the jump-register stall from the jump forwarding unit, the load-use stall and ID-stage redirects. From these it produces one consistent set of per-stage enable and flush controls. It also runs the halt drain sequence and keeps saturating stall-cycle counters for performance reporting.

---
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges cache, jump-register,
// load-use and redirect requests into per-stage enables, runs the halt drain.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             stall_j,
  input  logic             stall_lu,
  input  logic             redirect,
  input  logic             halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             done,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] haz_stall_cnt
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t         state;
  logic [DCW-1:0] drainCnt;
  logic           mem;
  logic           haz;

  assign mem = icache_stall | dcache_stall;
  assign haz = stall_j | stall_lu;

  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    case (state)
      RUN: begin
        if (mem) begin
          // whole pipe frozen
        end else if (haz) begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end else if (halt) begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = redirect;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end
      end
      DRAIN: begin
        // Front end stays frozen while bubbles push the halt out the back.
        if (!mem) begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      drainCnt      <= '0;
      done          <= 1'b0;
      mem_stall_cnt <= '0;
      haz_stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!mem && !haz && halt) begin
            state    <= DRAIN;
            drainCnt <= DCW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (!mem) begin
            drainCnt <= drainCnt - 1'b1;
            if (drainCnt == DCW'(1)) begin
              state <= HALTED;
              done  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase

      // Saturating performance counters; frozen once halted.
      if (state != HALTED && mem && mem_stall_cnt != '1)
        mem_stall_cnt <= mem_stall_cnt + 1'b1;
      if (state == RUN && haz && !mem && haz_stall_cnt != '1)
        haz_stall_cnt <= haz_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a directed vector table, reset corner cases
// and randomized traffic against a behavioural model; two DUTs (CNT_W=16 and 4).
module tb_pipeline_hazard_ctrl;

  localparam int DC = 3;
  localparam logic [6:0] ALL1  = 7'b1101011;
  localparam logic [6:0] FROZE = 7'b0000000;
  localparam logic [6:0] BUBL  = 7'b0001111;
  localparam logic [6:0] HALTO = 7'b0001011;
  localparam logic [6:0] REDIR = 7'b1111011;

  logic clk = 1'b0;
  logic rst_n;
  logic ic, dc, sj, slu, rd, ht;
  always #5 clk = ~clk;

  logic pcA, ifidA, ifflA, idexA, idflA, exA, wbA, doneA;
  logic pcB, ifidB, ifflB, idexB, idflB, exB, wbB, doneB;
  logic [15:0] memA, hazA;
  logic [3:0]  memB, hazB;
  logic [6:0]  outA, outB;
  assign outA = {pcA, ifidA, ifflA, idexA, idflA, exA, wbA};
  assign outB = {pcB, ifidB, ifflB, idexB, idflB, exB, wbB};

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .icache_stall(ic), .dcache_stall(dc),
    .stall_j(sj), .stall_lu(slu), .redirect(rd), .halt(ht),
    .pc_en(pcA), .ifid_en(ifidA), .ifid_flush(ifflA), .idex_en(idexA),
    .idex_flush(idflA), .exmem_en(exA), .memwb_en(wbA), .done(doneA),
    .mem_stall_cnt(memA), .haz_stall_cnt(hazA));

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .icache_stall(ic), .dcache_stall(dc),
    .stall_j(sj), .stall_lu(slu), .redirect(rd), .halt(ht),
    .pc_en(pcB), .ifid_en(ifidB), .ifid_flush(ifflB), .idex_en(idexB),
    .idex_flush(idflB), .exmem_en(exB), .memwb_en(wbB), .done(doneB),
    .mem_stall_cnt(memB), .haz_stall_cnt(hazB));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: raw event counts, drain as remaining bubble budget.
  bit mHalted;
  int mDrain;
  int mMem, mHaz;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic logic [6:0] expOut();
    logic memE, hazE;
    memE = ic | dc;
    hazE = sj | slu;
    if (mHalted || memE) return FROZE;
    if (mDrain > 0)      return BUBL;
    if (hazE)            return BUBL;
    if (ht)              return HALTO;
    if (rd)              return REDIR;
    return ALL1;
  endfunction

  task automatic modelReset();
    mHalted = 0; mDrain = 0; mMem = 0; mHaz = 0;
  endtask

  task automatic modelEdge();
    logic memE, hazE;
    memE = ic | dc;
    hazE = sj | slu;
    if (mHalted) return;
    if (memE) mMem++;
    if (mDrain > 0) begin
      if (!memE) begin
        if (mDrain == 1) mHalted = 1;
        mDrain--;
      end
    end else if (!memE) begin
      if (hazE) mHaz++;
      else if (ht) mDrain = DC;
    end
  endtask

  task automatic checkModel(input string tag);
    check({tag, ".outA"}, 32'(outA), 32'(expOut()));
    check({tag, ".outB"}, 32'(outB), 32'(expOut()));
    check({tag, ".doneA"}, 32'(doneA), 32'(mHalted));
    check({tag, ".doneB"}, 32'(doneB), 32'(mHalted));
    check({tag, ".memA"}, 32'(memA), 32'(sat(mMem, 16)));
    check({tag, ".hazA"}, 32'(hazA), 32'(sat(mHaz, 16)));
    check({tag, ".memB"}, 32'(memB), 32'(sat(mMem, 4)));
    check({tag, ".hazB"}, 32'(hazB), 32'(sat(mHaz, 4)));
  endtask

  typedef struct {
    logic [5:0] in;   // {icache, dcache, stall_j, stall_lu, redirect, halt}
    logic [6:0] out;
    logic       dn;
    int         memC;
    int         hazC;
  } vec_t;

  vec_t tbl[22];

  // Apply one cycle of inputs from posedge+1, check mid-cycle, advance model at edge.
  task automatic step(input logic [5:0] in, input int idx, input string tag);
    {ic, dc, sj, slu, rd, ht} = in;
    #3;
    if (idx >= 0) begin
      check($sformatf("tbl%0d.out", idx), 32'(outA), 32'(tbl[idx].out));
      check($sformatf("tbl%0d.done", idx), 32'(doneA), 32'(tbl[idx].dn));
      check($sformatf("tbl%0d.mem", idx), 32'(memA), 32'(tbl[idx].memC));
      check($sformatf("tbl%0d.haz", idx), 32'(hazA), 32'(tbl[idx].hazC));
    end
    checkModel(tag);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset(input string tag);
    {ic, dc, sj, slu, rd, ht} = 6'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    check({tag, ".out"}, 32'(outA), 32'(ALL1));
    check({tag, ".done"}, 32'(doneA), 32'd0);
    check({tag, ".mem"}, 32'(memA), 32'd0);
    check({tag, ".haz"}, 32'(hazA), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{6'b000000, ALL1,  1'b0, 0, 0};
    tbl[1]  = '{6'b001000, BUBL,  1'b0, 0, 0};
    tbl[2]  = '{6'b001000, BUBL,  1'b0, 0, 1};
    tbl[3]  = '{6'b000000, ALL1,  1'b0, 0, 2};
    tbl[4]  = '{6'b010110, FROZE, 1'b0, 0, 2};
    tbl[5]  = '{6'b010110, FROZE, 1'b0, 1, 2};
    tbl[6]  = '{6'b010110, FROZE, 1'b0, 2, 2};
    tbl[7]  = '{6'b000000, ALL1,  1'b0, 3, 2};
    tbl[8]  = '{6'b000010, REDIR, 1'b0, 3, 2};
    tbl[9]  = '{6'b000000, ALL1,  1'b0, 3, 2};
    tbl[10] = '{6'b100001, FROZE, 1'b0, 3, 2};
    tbl[11] = '{6'b001001, BUBL,  1'b0, 4, 2};
    tbl[12] = '{6'b000011, HALTO, 1'b0, 4, 3};
    tbl[13] = '{6'b000000, BUBL,  1'b0, 4, 3};
    tbl[14] = '{6'b010000, FROZE, 1'b0, 4, 3};
    tbl[15] = '{6'b010000, FROZE, 1'b0, 5, 3};
    tbl[16] = '{6'b000000, BUBL,  1'b0, 6, 3};
    tbl[17] = '{6'b001011, BUBL,  1'b0, 6, 3};
    tbl[18] = '{6'b000000, FROZE, 1'b1, 6, 3};
    tbl[19] = '{6'b010000, FROZE, 1'b1, 6, 3};
    tbl[20] = '{6'b000100, FROZE, 1'b1, 6, 3};
    tbl[21] = '{6'b000000, FROZE, 1'b1, 6, 3};

    {ic, dc, sj, slu, rd, ht} = 6'b0;
    rst_n = 1'b0;
    modelReset();
    #12;
    check("reset.out", 32'(outA), 32'(ALL1));
    check("reset.done", 32'(doneA), 32'd0);
    check("reset.memA", 32'(memA), 32'd0);
    check("reset.hazA", 32'(hazA), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(6'b000000, -1, "idle");
    check("idle10.mem", 32'(memA), 32'd0);
    check("idle10.haz", 32'(hazA), 32'd0);

    doReset("rst0");
    for (int i = 0; i < 22; i++) step(tbl[i].in, i, "tbl");

    // Saturation of the narrow counters.
    doReset("rst1");
    for (int i = 0; i < 20; i++) step(6'b000100, -1, "sat");
    check("sat.hazB", 32'(hazB), 32'd15);
    check("sat.hazA", 32'(hazA), 32'd20);

    // Reset asserted mid-DRAIN after counters have moved.
    doReset("rst2");
    step(6'b000100, -1, "pre");
    step(6'b010000, -1, "pre");
    step(6'b000001, -1, "halt");
    step(6'b000000, -1, "drain");
    doReset("midDrain");
    step(6'b000000, -1, "postDrainRst");

    // Reset asserted while HALTED.
    step(6'b000001, -1, "halt2");
    for (int i = 0; i < DC; i++) step(6'b000000, -1, "drain2");
    check("halted.done", 32'(doneA), 32'd1);
    doReset("inHalted");
    step(6'b000000, -1, "postHaltRst");

    // Randomized traffic; reset a few cycles after each halt completes.
    begin
      int haltedFor;
      logic [5:0] in;
      haltedFor = 0;
      for (int n = 0; n < 3000; n++) begin
        if (mHalted) haltedFor++;
        if (haltedFor > 4) begin
          doReset("rndRst");
          haltedFor = 0;
        end
        in[5] = ($urandom_range(0, 9) == 0);
        in[4] = ($urandom_range(0, 9) == 0);
        in[3] = ($urandom_range(0, 7) == 0);
        in[2] = ($urandom_range(0, 7) == 0);
        in[1] = ($urandom_range(0, 3) == 0);
        in[0] = ($urandom_range(0, 19) == 0);
        step(in, -1, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
